// File: rtl/washer_pkg.sv
// Shared types, program durations and phase-time helpers for the wash-cycle sequencer.
package washer_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FILL_W  = 4'd1,
    S_WASH    = 4'd2,
    S_DRAIN_W = 4'd3,
    S_FILL_R  = 4'd4,
    S_RINSE   = 4'd5,
    S_DRAIN_R = 4'd6,
    S_SPIN    = 4'd7,
    S_DONE    = 4'd8,
    S_PAUSE   = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    MOTOR_OFF     = 2'd0,
    MOTOR_AGITATE = 2'd1,
    MOTOR_SPIN    = 2'd2
  } motor_t;

  typedef enum logic [1:0] {
    PROG_NONE  = 2'd0,
    PROG_BASIC = 2'd1,
    PROG_COLD  = 2'd2,
    PROG_SUPER = 2'd3
  } prog_t;

  localparam logic [7:0] BASIC_WASH = 8'd6;
  localparam logic [7:0] BASIC_RINSE = 8'd3;
  localparam logic [7:0] BASIC_SPIN = 8'd3;
  localparam logic [7:0] COLD_WASH = 8'd10;
  localparam logic [7:0] COLD_RINSE = 8'd5;
  localparam logic [7:0] COLD_SPIN = 8'd5;
  localparam logic [7:0] SUPER_WASH = 8'd15;
  localparam logic [7:0] SUPER_RINSE = 8'd8;
  localparam logic [7:0] SUPER_SPIN = 8'd10;

  typedef struct packed {
    logic       valve;
    logic       pump;
    logic [1:0] motor;
    logic       door_lock;
    logic       busy;
    logic       done;
    logic [7:0] time_left;
    logic [3:0] led;
  } out_t;

  function automatic logic is_running(state_t s);
    return (s >= S_FILL_W) && (s <= S_SPIN);
  endfunction

  function automatic logic is_timed(state_t s);
    return (s == S_WASH) || (s == S_RINSE) || (s == S_SPIN);
  endfunction

  function automatic logic [7:0] phase_secs(prog_t p, state_t s);
    logic [7:0] w, r, sp;
    case (p)
      PROG_BASIC: begin w = BASIC_WASH; r = BASIC_RINSE; sp = BASIC_SPIN; end
      PROG_COLD:  begin w = COLD_WASH;  r = COLD_RINSE;  sp = COLD_SPIN;  end
      PROG_SUPER: begin w = SUPER_WASH; r = SUPER_RINSE; sp = SUPER_SPIN; end
      default:    begin w = 8'd0;       r = 8'd0;        sp = 8'd0;       end
    endcase
    case (s)
      S_WASH:  return w;
      S_RINSE: return r;
      S_SPIN:  return sp;
      default: return 8'd0;
    endcase
  endfunction

  // Full durations of the timed phases that still lie ahead of state s.
  function automatic logic [7:0] rest_after(prog_t p, state_t s);
    logic [7:0] w, r, sp;
    w  = phase_secs(p, S_WASH);
    r  = phase_secs(p, S_RINSE);
    sp = phase_secs(p, S_SPIN);
    case (s)
      S_FILL_W:                      return w + r + sp;
      S_WASH, S_DRAIN_W, S_FILL_R:   return r + sp;
      S_RINSE, S_DRAIN_R:            return sp;
      default:                       return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/wash_cycle_ctrl_if.sv
// Washer I/O bundle: program selects, door and level sensors in; actuators and display out.
interface wash_cycle_ctrl_if;
  logic       give_BB;
  logic       give_CB;
  logic       give_SB;
  logic       door_closed;
  logic       level_full;
  logic       level_empty;
  logic       valve;
  logic       pump;
  logic [1:0] motor;
  logic       door_lock;
  logic       busy;
  logic       done;
  logic [7:0] time_left;
  logic [3:0] led;

  modport master (
    output give_BB, give_CB, give_SB, door_closed, level_full, level_empty,
    input  valve, pump, motor, door_lock, busy, done, time_left, led
  );

  modport slave (
    input  give_BB, give_CB, give_SB, door_closed, level_full, level_empty,
    output valve, pump, motor, door_lock, busy, done, time_left, led
  );
endinterface

// File: rtl/wash_cycle_ctrl_tick_prescaler.sv
// One-second tick generator: pulses tick every TICK_DIV enabled cycles; clr restarts the count.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Not gated by clr: clr is derived from the FSM's next state, which depends on tick.
  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/wash_cycle_ctrl.sv
// Wash-cycle sequencer: program latch, phase FSM with door-pause, phase timer and Moore output decode.
module wash_cycle_ctrl
  import washer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  wash_cycle_ctrl_if.slave  bus
);

  state_t     r_state, r_saved, w_nxt_state, w_nxt_saved;
  prog_t      r_prog, w_nxt_prog;
  logic [7:0] r_timer, w_nxt_timer;
  logic [2:0] r_sel_d, w_sel, w_rise;
  logic       w_tick, w_clr, w_en;
  out_t       r_out;

  assign w_sel  = {bus.give_SB, bus.give_CB, bus.give_BB};
  assign w_rise = w_sel & ~r_sel_d;
  assign w_clr  = (w_nxt_state != r_state);
  assign w_en   = is_timed(r_state);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (reset),
    .clr   (w_clr),
    .en    (w_en),
    .tick  (w_tick)
  );

  function automatic out_t decode(state_t s, state_t sv, logic [7:0] t, prog_t p);
    out_t   o;
    state_t ph;
    o     = '0;
    o.led = s;
    ph    = (s == S_PAUSE) ? sv : s;
    if (is_running(ph)) o.time_left = (is_timed(ph) ? t : 8'd0) + rest_after(p, ph);
    case (s)
      S_FILL_W, S_FILL_R:   o.valve = 1'b1;
      S_WASH, S_RINSE:      o.motor = MOTOR_AGITATE;
      S_DRAIN_W, S_DRAIN_R: o.pump = 1'b1;
      S_SPIN:               begin o.motor = MOTOR_SPIN; o.pump = 1'b1; end
      S_DONE:               o.done = 1'b1;
      default:              o.done = 1'b0;
    endcase
    o.door_lock = is_running(s);
    o.busy      = is_running(s) || (s == S_PAUSE);
    return o;
  endfunction

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_saved = r_saved;
    w_nxt_prog  = r_prog;
    w_nxt_timer = r_timer;
    case (r_state)
      S_IDLE: begin
        if (bus.door_closed && (|w_rise)) begin
          w_nxt_state = S_FILL_W;
          w_nxt_prog  = w_rise[2] ? PROG_SUPER : (w_rise[1] ? PROG_COLD : PROG_BASIC);
        end
      end
      S_DONE: begin
        if (!bus.door_closed) begin
          w_nxt_state = S_IDLE;
          w_nxt_prog  = PROG_NONE;
        end
      end
      S_PAUSE: begin
        if (bus.door_closed) w_nxt_state = r_saved;
      end
      S_FILL_W, S_WASH, S_DRAIN_W, S_FILL_R, S_RINSE, S_DRAIN_R, S_SPIN: begin
        // An open door outranks every sensor and tick event, including a phase-ending tick.
        if (!bus.door_closed) begin
          w_nxt_state = S_PAUSE;
          w_nxt_saved = r_state;
        end else begin
          case (r_state)
            S_FILL_W: if (bus.level_full) begin
              w_nxt_state = S_WASH;
              w_nxt_timer = phase_secs(r_prog, S_WASH);
            end
            S_DRAIN_W: if (bus.level_empty) w_nxt_state = S_FILL_R;
            S_FILL_R: if (bus.level_full) begin
              w_nxt_state = S_RINSE;
              w_nxt_timer = phase_secs(r_prog, S_RINSE);
            end
            S_DRAIN_R: if (bus.level_empty) begin
              w_nxt_state = S_SPIN;
              w_nxt_timer = phase_secs(r_prog, S_SPIN);
            end
            default: if (w_tick) begin
              if (r_timer <= 8'd1) begin
                w_nxt_timer = 8'd0;
                w_nxt_state = (r_state == S_WASH)  ? S_DRAIN_W :
                              (r_state == S_RINSE) ? S_DRAIN_R : S_DONE;
              end else begin
                w_nxt_timer = r_timer - 8'd1;
              end
            end
          endcase
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the decode of the next state so they track r_state exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_saved <= S_IDLE;
      r_prog  <= PROG_NONE;
      r_timer <= 8'd0;
      r_sel_d <= 3'b000;
      r_out   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_saved <= w_nxt_saved;
      r_prog  <= w_nxt_prog;
      r_timer <= w_nxt_timer;
      r_sel_d <= w_sel;
      r_out   <= decode(w_nxt_state, w_nxt_saved, w_nxt_timer, w_nxt_prog);
    end
  end

  assign bus.valve     = r_out.valve;
  assign bus.pump      = r_out.pump;
  assign bus.motor     = r_out.motor;
  assign bus.door_lock = r_out.door_lock;
  assign bus.busy      = r_out.busy;
  assign bus.done      = r_out.done;
  assign bus.time_left = r_out.time_left;
  assign bus.led       = r_out.led;

endmodule
